// File: rtl/semaforo_pkg.sv
// Shared definitions for the intersection controllers.
// Holds the pedestrian-head state encoding, the default 50 MHz durations
// of the pedestrian controller, and the vehicle light timing constants.
package semaforo_pkg;

    // Pedestrian controller state encoding
    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_WALK  = 2'b01,
        ST_FLASH = 2'b10,
        ST_FAULT = 2'b11
    } ped_state_t;

    localparam int unsigned CLK_HZ = 50_000_000;

    // Pedestrian durations at 50 MHz
    localparam int unsigned PED_WALK_CYCLES     = 30_000_000;  // 0.6 s steady WALK
    localparam int unsigned PED_FLASH_CYCLES    = 15_000_000;  // 0.3 s clearance
    localparam int unsigned PED_FLASH_HALF      = 6_250_000;   // blink half-period
    localparam int unsigned PED_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms stable press
    localparam int unsigned PED_CNT_W           = 26;

    // Vehicle light durations at 50 MHz
    localparam int unsigned VEH_GREEN_CYCLES  = 1_000_000_000; // 20 s
    localparam int unsigned VEH_YELLOW_CYCLES = 150_000_000;   // 3 s
    localparam int unsigned VEH_RED_CYCLES    = 1_000_000_000; // 20 s
    localparam int unsigned VEH_CNT_W         = 30;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter, rise detect.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   btn_raw   - raw asynchronous, bouncy button
//   level     - debounced level, high after DEBOUNCE_CYCLES stable high samples
//   press     - high in the cycle whose closing edge raises level
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Counter saturates at DEBOUNCE_CYCLES; press is the decode that flips level
    // on the coming edge, so downstream logic sees the press on that same edge.
    assign press = sync2 & ~level & (cnt == CNT_W'(DEBOUNCE_CYCLES));

    // Synchronizer, debounce counter and level register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            if (!sync2) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (press) begin
                level <= 1'b1;
            end else if (!level) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pedestrian_signal.sv
// Pedestrian crossing controller slaved to the vehicle light FSM.
// A latched button request gets a WALK phase at the next vehicle red rise,
// followed by a blinking DON'T WALK clearance. Lamp conflicts lock into FAULT.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   red, yellow, green - registered vehicle lamps (same clock domain)
//   ped_btn            - raw pedestrian push-button
//   walk, dont_walk    - pedestrian heads
//   req_pending        - request latched (wait indicator)
//   fault              - sticky lamp-conflict flag
module pedestrian_signal
    import semaforo_pkg::*;
#(
    parameter int unsigned WALK_CYCLES     = PED_WALK_CYCLES,
    parameter int unsigned FLASH_CYCLES    = PED_FLASH_CYCLES,
    parameter int unsigned FLASH_HALF      = PED_FLASH_HALF,
    parameter int unsigned DEBOUNCE_CYCLES = PED_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = PED_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic red,
    input  logic yellow,
    input  logic green,
    input  logic ped_btn,
    output logic walk,
    output logic dont_walk,
    output logic req_pending,
    output logic fault
);

    ped_state_t       state;
    ped_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] half_cnt;
    logic [CNT_W-1:0] half_next;
    logic             blink;
    logic             blink_next;
    logic             req_next;
    logic             red_d;
    logic             btn_level;
    logic             btn_press;
    logic             new_press;
    logic             red_rise;
    logic             conflict;
    logic             unsafe;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_btn (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(ped_btn),
        .level  (btn_level),
        .press  (btn_press)
    );

    // Press qualifier: only a low-to-high transition of the debounced level counts
    assign new_press = btn_press & ~btn_level;
    assign red_rise  = red & ~red_d;
    assign conflict  = red & (yellow | green);
    assign unsafe    = ~red | yellow | green;

    // Next-state, counters, blink phase and request latch
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        half_next  = '0;
        blink_next = 1'b0;
        req_next   = req_pending;

        if (conflict || state == ST_FAULT) begin
            state_next = ST_FAULT;
        end else begin
            case (state)
                ST_STOP: begin
                    if (red_rise && (req_pending || new_press)) begin
                        state_next = ST_WALK;
                    end else if (new_press) begin
                        req_next = 1'b1;
                    end
                end
                ST_WALK: begin
                    if (unsafe) begin
                        state_next = ST_STOP;
                    end else if (cnt == CNT_W'(WALK_CYCLES - 1)) begin
                        state_next = ST_FLASH;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                ST_FLASH: begin
                    if (new_press) begin
                        req_next = 1'b1;
                    end
                    if (unsafe || cnt == CNT_W'(FLASH_CYCLES - 1)) begin
                        state_next = ST_STOP;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                        if (half_cnt == CNT_W'(FLASH_HALF - 1)) begin
                            blink_next = ~blink;
                        end else begin
                            blink_next = blink;
                            half_next  = half_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state_next = ST_FAULT;
            endcase
        end

        // The request is consumed on entry to WALK, including a same-cycle press
        if (state_next == ST_WALK && state != ST_WALK) begin
            req_next = 1'b0;
        end
    end

    // State, counters and registered head outputs decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_STOP;
            cnt         <= '0;
            half_cnt    <= '0;
            blink       <= 1'b0;
            req_pending <= 1'b0;
            red_d       <= 1'b0;
            walk        <= 1'b0;
            dont_walk   <= 1'b1;
            fault       <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            half_cnt    <= half_next;
            blink       <= blink_next;
            req_pending <= req_next;
            red_d       <= red;
            walk        <= (state_next == ST_WALK);
            dont_walk   <= (state_next == ST_FLASH) ? blink_next : (state_next != ST_WALK);
            fault       <= (state_next == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_pedestrian_signal.sv
// Directed bench for pedestrian_signal with short durations
// (WALK 8, FLASH 8, blink half-period 2, debounce 4).
module tb_pedestrian_signal;

    logic clk = 1'b0;
    logic rst;
    logic red;
    logic yellow;
    logic green;
    logic ped_btn;
    logic walk;
    logic dont_walk;
    logic req_pending;
    logic fault;

    int total = 0;
    int bad   = 0;

    logic [7:0] blink_pat;

    always #5 clk = ~clk;

    pedestrian_signal #(
        .WALK_CYCLES    (8),
        .FLASH_CYCLES   (8),
        .FLASH_HALF     (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .ped_btn    (ped_btn),
        .walk       (walk),
        .dont_walk  (dont_walk),
        .req_pending(req_pending),
        .fault      (fault)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then read 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        red     = 1'b0;
        yellow  = 1'b0;
        green   = 1'b0;
        ped_btn = 1'b0;
        blink_pat = 8'b1100_1100;

        #12;
        check("rst_walk", walk, 1'b0);
        check("rst_dont_walk", dont_walk, 1'b1);
        check("rst_req", req_pending, 1'b0);
        check("rst_fault", fault, 1'b0);
        rst = 1'b0;

        // Normal grant: press during green, then green -> red
        green = 1'b1;
        step(); step();
        ped_btn = 1'b1;
        repeat (6) step();
        ped_btn = 1'b0;
        check("press_early", req_pending, 1'b0);
        step();
        check("press_latched", req_pending, 1'b1);
        check("green_no_walk", walk, 1'b0);
        green = 1'b0;
        red   = 1'b1;
        step();
        check("walk_start", walk, 1'b1);
        check("walk_start_dw", dont_walk, 1'b0);
        check("walk_req_clear", req_pending, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step();
            check("walk_hold", walk, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            check("flash_walk", walk, 1'b0);
            check("flash_blink", dont_walk, blink_pat[i]);
        end
        step();
        check("grant_end_walk", walk, 1'b0);
        check("grant_end_dw", dont_walk, 1'b1);

        // Red rise with no request stays in STOP
        red   = 1'b0;
        green = 1'b1;
        repeat (3) step();
        green = 1'b0;
        red   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("noreq_walk", walk, 1'b0);
        end
        check("noreq_dw", dont_walk, 1'b1);

        // Bounce: 3 high / 1 low never reaches 4 stable samples
        red   = 1'b0;
        green = 1'b1;
        step();
        repeat (5) begin
            ped_btn = 1'b1;
            repeat (3) step();
            ped_btn = 1'b0;
            step();
            check("bounce_req", req_pending, 1'b0);
        end
        repeat (4) step();
        check("bounce_req_end", req_pending, 1'b0);

        // Abort: red drops 3 cycles into WALK
        ped_btn = 1'b1;
        repeat (6) step();
        ped_btn = 1'b0;
        step();
        check("abort_req", req_pending, 1'b1);
        green = 1'b0;
        red   = 1'b1;
        step();
        check("abort_walk_in", walk, 1'b1);
        step(); step();
        check("abort_walk_mid", walk, 1'b1);
        red   = 1'b0;
        green = 1'b1;
        step();
        check("abort_walk", walk, 1'b0);
        check("abort_dw", dont_walk, 1'b1);
        check("abort_req_gone", req_pending, 1'b0);
        step();
        green = 1'b0;
        red   = 1'b1;
        step();
        check("abort_no_regrant", walk, 1'b0);
        repeat (3) step();
        check("abort_no_regrant2", walk, 1'b0);

        // Request made while red is already on waits for the next red rise
        ped_btn = 1'b1;
        repeat (6) step();
        ped_btn = 1'b0;
        step();
        check("redon_req", req_pending, 1'b1);
        check("redon_walk", walk, 1'b0);
        repeat (3) step();
        check("redon_wait", walk, 1'b0);
        red   = 1'b0;
        green = 1'b1;
        step();
        green = 1'b0;
        red   = 1'b1;
        step();
        check("redon_grant", walk, 1'b1);
        check("redon_req_clear", req_pending, 1'b0);

        // Asynchronous reset in the middle of WALK
        repeat (3) step();
        check("pre_rst_walk", walk, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_walk", walk, 1'b0);
        check("arst_dw", dont_walk, 1'b1);
        check("arst_req", req_pending, 1'b0);
        #2 rst = 1'b0;

        // Fault: one-cycle red+green conflict is sticky
        green = 1'b1;
        step();
        green = 1'b0;
        check("fault_set", fault, 1'b1);
        check("fault_dw", dont_walk, 1'b1);
        check("fault_walk", walk, 1'b0);
        for (int i = 0; i < 3; i++) begin
            red = 1'b0;
            step();
            red = 1'b1;
            step();
            check("fault_hold", fault, 1'b1);
            check("fault_hold_dw", dont_walk, 1'b1);
        end
        ped_btn = 1'b1;
        repeat (6) step();
        ped_btn = 1'b0;
        step();
        red = 1'b0;
        step();
        red = 1'b1;
        step();
        check("fault_press", fault, 1'b1);
        check("fault_press_walk", walk, 1'b0);
        check("fault_press_dw", dont_walk, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("fault_rst", fault, 1'b0);
        check("fault_rst_dw", dont_walk, 1'b1);
        #2 rst = 1'b0;
        step();
        check("fault_cleared", fault, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pedestrian_signal.md
# pedestrian_signal

Pedestrian crossing controller directly downstream of the vehicle traffic-light FSM. Consumes its registered `red`/`yellow`/`green` lamps, plus a raw pedestrian push-button. Drives the WALK / DON'T WALK heads: a latched request is granted a walk phase at the start of the next vehicle red, followed by a flashing DON'T WALK clearance. Any vehicle light conflict forces DON'T WALK.

## Interface
- `WALK_CYCLES`, 30000000: steady WALK duration in clocks.
- `FLASH_CYCLES`, 15000000: flashing clearance duration in clocks.
- `FLASH_HALF`, 6250000: half-period of the DON'T WALK blink in clocks.
- `DEBOUNCE_CYCLES`, 1000000: clocks the button must be stably high to register a press.
- `CNT_W`, 26: width of all duration counters; every duration parameter must fit in `CNT_W` bits.
- `clk  in  1`: system clock, same clock as the vehicle FSM.
- `rst  in  1`: asynchronous, active-high reset.
- `red  in  1`: vehicle red lamp, synchronous to `clk`.
- `yellow  in  1`: vehicle yellow lamp, synchronous.
- `green  in  1`: vehicle green lamp, synchronous.
- `ped_btn  in  1`: raw push-button, asynchronous and bouncy.
- `walk  out  1`: WALK head.
- `dont_walk  out  1`: DON'T WALK head; steady or blinking.
- `req_pending  out  1`: "wait" indicator; a request is latched.
- `fault  out  1`: sticky lamp-conflict flag.

## Operation
- **Button path:**
  - `ped_btn` passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level goes high after `DEBOUNCE_CYCLES` consecutive high samples. It goes low on the first low sample.
  - A rising edge of the debounced level is a press.
- **`req_pending`:**
  - Set by a press in STOP or FLASH.
  - Presses during WALK are ignored.
  - Cleared on the transition into WALK.
- **Red-edge detection:** `red_d` registers `red`; `red_rise = red & ~red_d`. The vehicle inputs need no synchronizer.
- **States:** STOP (reset), WALK, FLASH, FAULT.
  - **STOP:** if `red_rise` and (`req_pending` or a press this cycle), go to WALK. A request pending while red is already on waits for the next red rise.
  - **WALK:** stay for exactly `WALK_CYCLES` cycles, then go to FLASH.
  - **FLASH:** stay for exactly `FLASH_CYCLES` cycles, then go to STOP.
  - **Safety abort:** in WALK or FLASH, if `red`=0, `yellow`=1 or `green`=1, go to STOP on the next edge. The consumed request is not restored.
  - **FAULT entry:** `red & (yellow | green)` in any state goes to FAULT, which has priority over all other transitions.
  - **FAULT exit:** only by `rst`. `fault`=1 in FAULT.
- **Outputs:** Moore decode of the state register.
  - STOP: `walk`=0, `dont_walk`=1.
  - WALK: `walk`=1, `dont_walk`=0.
  - FLASH: `walk`=0, `dont_walk`=blink phase.
  - FAULT: `walk`=0, `dont_walk`=1.
- **Blink phase:**
  - Starts at 0 on entry to FLASH.
  - Toggles after every `FLASH_HALF` cycles in FLASH.
  - Forced to 0 outside FLASH.
- **Counters:**
  - The duration counter is cleared on every state change.
  - It counts 0..N-1 for the current state's duration N.
  - No wrap-around is possible, given the parameter constraint above.

## Timing
- **Reset values:** `walk`=0, `dont_walk`=1, `req_pending`=0, `fault`=0, state=STOP, all counters 0, synchronizer flops 0.
- **Press latency:** button high at edge k, steady, gives debounced high at edge k+2+`DEBOUNCE_CYCLES`; `req_pending` is 1 from that edge.
- **Walk start:** vehicle `red` first sampled 1 at edge k gives `walk`=1 from edge k (the same edge at which `red_d` rises). Latency is 1 clock from the lamp change.
- **Abort:** `red` sampled 0 at edge k gives `walk`=0, `dont_walk`=1 from edge k.
- **Simultaneous events:**
  - Press plus `red_rise` in STOP enters WALK with `req_pending`=0.
  - Conflict plus any other event enters FAULT.

## Structure
- **Shared package `semaforo_pkg`:** 2-bit state encoding (STOP=00, WALK=01, FLASH=10, FAULT=11) and the default 50 MHz duration constants. The vehicle FSM timing constants move there too.
- **Sub-module `btn_debounce`:** parameters `DEBOUNCE_CYCLES`, `CNT_W`; ports `clk`, `rst`, `btn_raw`, `level`, `press`. It contains the synchronizer, debounce counter and edge detector.

## Test plan
All scenarios use `WALK_CYCLES`=8, `FLASH_CYCLES`=8, `FLASH_HALF`=2, `DEBOUNCE_CYCLES`=4.
1. **Reset:** assert `rst` mid-WALK → `walk`=0, `dont_walk`=1, `req_pending`=0 immediately (asynchronously).
2. **Normal grant:** 6-cycle button press during green, then green→red → `req_pending`=1 after 6 edges. `walk`=1 for exactly 8 cycles, then `dont_walk` blinks 0,0,1,1,0,0,1,1, then STOP. `req_pending` clears at WALK entry.
3. **No request:** red rises with `req_pending`=0 → stays STOP, `walk` never 1.
4. **Bounce reject:** button high for 3 cycles, low 1 cycle, repeated 5 times → `req_pending` stays 0.
5. **Abort:** red drops 3 cycles into WALK → STOP on that edge; a fresh press is required for the next grant.
6. **Fault:** `red`=1 and `green`=1 for one cycle → `fault`=1, `dont_walk`=1 steady. Both held through later red rises and presses until `rst`.
